// File: rtl/relu_maxpool_2x2_if.sv
// Stream bundle between the convolution engine, the ReLU/max-pool stage and its consumer.
interface relu_maxpool_2x2_if #(
  parameter int IN_W = 22
);
  logic                   start_signal;
  logic signed [IN_W-1:0] in_data;
  logic                   in_valid;
  logic                   in_done;
  logic [7:0]             pool_out;
  logic                   pool_valid;
  logic                   done_signal;
  logic                   frame_err;

  modport master (
    output start_signal, in_data, in_valid, in_done,
    input  pool_out, pool_valid, done_signal, frame_err
  );

  modport slave (
    input  start_signal, in_data, in_valid, in_done,
    output pool_out, pool_valid, done_signal, frame_err
  );
endinterface

// File: rtl/relu_maxpool_2x2.sv
// ReLU + shift/saturate requantization to u8, then 2x2 stride-2 max pooling over a
// row-major result stream, using one half-width row buffer.
module relu_maxpool_2x2 #(
  parameter int FMAP_W = 30,
  parameter int FMAP_H = 30,
  parameter int IN_W   = 22,
  parameter int SHIFT  = 4
) (
  input logic               clk,
  input logic               rst,
  relu_maxpool_2x2_if.slave bus
);
  localparam int CW = (FMAP_W / 2 > 1) ? $clog2(FMAP_W / 2) : 1;
  localparam int XW = CW + 1;
  localparam int YW = (FMAP_H > 2) ? $clog2(FMAP_H) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [7:0] quant(input logic signed [IN_W-1:0] v);
    logic [IN_W-1:0] s;
    if (v[IN_W-1]) begin
      s = '0;
    end else begin
      s = $unsigned(v) >> SHIFT;
    end
    if (s > IN_W'(255)) begin
      quant = 8'd255;
    end else begin
      quant = s[7:0];
    end
  endfunction

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    max8 = (a > b) ? a : b;
  endfunction

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [7:0]      hold_q, hold_d;
  logic [7:0]      pool_out_q, pool_out_d;
  logic            pool_valid_q, pool_valid_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [7:0]      row_buf_q [FMAP_W/2];

  logic [7:0]      q_s;
  logic [7:0]      hmax_s;
  logic [CW-1:0]   col_s;
  logic            last_s;
  logic            row_wr_s;

  assign q_s    = quant(bus.in_data);
  assign hmax_s = max8(hold_q, q_s);
  assign col_s  = x_q[XW-1:1];
  assign last_s = (x_q == XW'(FMAP_W - 1)) && (y_q == YW'(FMAP_H - 1));

  // Next-state, counter, pairing and output computation.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    hold_d       = hold_q;
    pool_out_d   = pool_out_q;
    pool_valid_d = 1'b0;
    done_d       = 1'b0;
    err_d        = err_q;
    row_wr_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        x_d = '0;
        y_d = '0;
        if (bus.start_signal) begin
          state_d = S_RUN;
          err_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.in_valid) begin
          if (!x_q[0]) begin
            hold_d = q_s;
          end else if (!y_q[0]) begin
            row_wr_s = 1'b1;
          end else begin
            pool_out_d   = max8(row_buf_q[col_s], hmax_s);
            pool_valid_d = 1'b1;
          end
          if (x_q == XW'(FMAP_W - 1)) begin
            x_d = '0;
            y_d = (y_q == YW'(FMAP_H - 1)) ? '0 : y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
        end else begin
          x_d = x_q;
        end
        // A done pulse only counts as an error when it is not the final element's own cycle.
        if (bus.in_valid && last_s) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (bus.in_done) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        x_d     = '0;
        y_d     = '0;
      end
      default: begin
        state_d = S_IDLE;
        x_d     = '0;
        y_d     = '0;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      hold_q       <= 8'd0;
      pool_out_q   <= 8'd0;
      pool_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      hold_q       <= hold_d;
      pool_out_q   <= pool_out_d;
      pool_valid_q <= pool_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Row buffer: every entry is rewritten on an even row before its odd-row read.
  always_ff @(posedge clk) begin
    if (row_wr_s) begin
      row_buf_q[col_s] <= hmax_s;
    end
  end

  assign bus.pool_out    = pool_out_q;
  assign bus.pool_valid  = pool_valid_q;
  assign bus.done_signal = done_q;
  assign bus.frame_err   = err_q;
endmodule
